// File: rtl/icache_ctrl_pkg.sv
// Shared geometry, FSM state type and address field helpers for the
// direct-mapped instruction cache.
package icache_ctrl_pkg;

    localparam int ADDR_W     = 32;
    localparam int INDEX_W    = 6;
    localparam int WORDS_LOG2 = 2;
    localparam int WORDS      = 1 << WORDS_LOG2;
    localparam int LINES      = 1 << INDEX_W;
    localparam int OFFSET_W   = WORDS_LOG2 + 2;
    localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;

    typedef logic [TAG_W-1:0]      tagT;
    typedef logic [INDEX_W-1:0]    indexT;
    typedef logic [WORDS_LOG2-1:0] wordT;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        DONE
    } stateT;

    function automatic tagT addrTag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic indexT addrIndex(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic wordT addrWord(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WORDS_LOG2];
    endfunction

    // Rebuild a word-aligned byte address from its cache fields.
    function automatic logic [ADDR_W-1:0] lineAddr(input tagT tag, input indexT idx, input wordT word);
        return {tag, idx, word, 2'b00};
    endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave = the cache controller, master = pipeline plus memory.
interface icache_ctrl_if;
    import icache_ctrl_pkg::*;

    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              flush;
    logic              hit;
    logic [31:0]       rdata;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_addr, flush, mem_ack, mem_rdata,
        output hit, rdata, mem_req, mem_addr
    );

    modport master (
        output req_valid, req_addr, flush, mem_ack, mem_rdata,
        input  hit, rdata, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_ctrl_arrays.sv
// Tag, valid and data storage for the direct-mapped cache: one write port,
// asynchronous read so the lookup result is available in the same cycle.
module icache_arrays
    import icache_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clearAll,
    input  logic        dataWe,
    input  logic        tagWe,
    input  indexT       wrIndex,
    input  wordT        wrWord,
    input  logic [31:0] wrData,
    input  tagT         wrTag,
    input  indexT       rdIndex,
    input  wordT        rdWord,
    output logic        rdValid,
    output tagT         rdTag,
    output logic [31:0] rdData
);

    logic [31:0] dataMem  [LINES*WORDS];
    tagT         tagMem   [LINES];
    logic        validReg [LINES];

    // Refill data write, one word per accepted memory beat.
    always_ff @(posedge clk) begin
        if (dataWe) begin
            dataMem[{wrIndex, wrWord}] <= wrData;
        end
    end

    // Tag is written together with the last beat of a refill.
    always_ff @(posedge clk) begin
        if (tagWe) begin
            tagMem[wrIndex] <= wrTag;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : gValid
            // Per-line valid bit; a clear always beats a set so a flush wins.
            always_ff @(posedge clk) begin
                if (reset || clearAll) begin
                    validReg[gi] <= 1'b0;
                end else if (tagWe && (wrIndex == indexT'(gi))) begin
                    validReg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign rdValid = validReg[rdIndex];
    assign rdTag   = tagMem[rdIndex];
    assign rdData  = dataMem[{rdIndex, rdWord}];

endmodule

// File: rtl/icache_ctrl.sv
// Blocking direct-mapped instruction cache controller. hit=0 stalls the
// pipeline while a missing line is fetched word by word from memory.
module icache_ctrl
    import icache_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    icache_ctrl_if.slave bus
);

    stateT             stateReg, stateNext;
    wordT              cntReg, cntNext;
    tagT               missTagReg, missTagNext;
    indexT             missIdxReg, missIdxNext;
    logic              memReqReg, memReqNext;
    logic [ADDR_W-1:0] memAddrReg, memAddrNext;
    logic              flushPendReg, flushPendNext;

    logic              clearAll;
    logic              dataWe;
    logic              tagWe;
    logic              lineValid;
    tagT               lineTag;
    logic [31:0]       lineData;
    tagT               reqTag;
    indexT             reqIdx;
    wordT              reqWord;
    logic              lookupHit;
    logic              unusedAddrBits;

    assign reqTag         = addrTag(bus.req_addr);
    assign reqIdx         = addrIndex(bus.req_addr);
    assign reqWord        = addrWord(bus.req_addr);
    assign unusedAddrBits = ^bus.req_addr[1:0];

    // Writes always target the latched miss line, never the live fetch address.
    icache_arrays uArrays (
        .clk      (clk),
        .reset    (reset),
        .clearAll (clearAll),
        .dataWe   (dataWe),
        .tagWe    (tagWe),
        .wrIndex  (missIdxReg),
        .wrWord   (cntReg),
        .wrData   (bus.mem_rdata),
        .wrTag    (missTagReg),
        .rdIndex  (reqIdx),
        .rdWord   (reqWord),
        .rdValid  (lineValid),
        .rdTag    (lineTag),
        .rdData   (lineData)
    );

    assign lookupHit    = lineValid && (lineTag == reqTag);
    assign bus.rdata    = lineData;
    assign bus.mem_req  = memReqReg;
    assign bus.mem_addr = memAddrReg;

    // Stall qualifier: only an idle cache can let the pipeline advance.
    always_comb begin
        bus.hit = 1'b0;
        if (!reset && (stateReg == IDLE)) begin
            bus.hit = !bus.req_valid || lookupHit;
        end
    end

    // Next-state logic for the refill FSM, beat counter and bus handshake.
    always_comb begin
        stateNext     = stateReg;
        cntNext       = cntReg;
        missTagNext   = missTagReg;
        missIdxNext   = missIdxReg;
        memReqNext    = memReqReg;
        memAddrNext   = memAddrReg;
        flushPendNext = flushPendReg;
        clearAll      = 1'b0;
        dataWe        = 1'b0;
        tagWe         = 1'b0;
        unique case (stateReg)
            IDLE: begin
                if (bus.flush) begin
                    clearAll = 1'b1;
                end else if (bus.req_valid && !lookupHit) begin
                    missTagNext = reqTag;
                    missIdxNext = reqIdx;
                    cntNext     = '0;
                    memReqNext  = 1'b1;
                    memAddrNext = lineAddr(reqTag, reqIdx, '0);
                    stateNext   = REFILL;
                end
            end
            REFILL: begin
                // A flush cannot abort a bus transfer; remember it for DONE.
                if (bus.flush) begin
                    flushPendNext = 1'b1;
                end
                if (memReqReg && bus.mem_ack && !reset) begin
                    dataWe = 1'b1;
                    if (cntReg == wordT'(WORDS-1)) begin
                        tagWe      = 1'b1;
                        memReqNext = 1'b0;
                        cntNext    = '0;
                        stateNext  = DONE;
                    end else begin
                        cntNext     = cntReg + 1'b1;
                        memAddrNext = lineAddr(missTagReg, missIdxReg, cntReg + 1'b1);
                    end
                end
            end
            DONE: begin
                if (flushPendReg || bus.flush) begin
                    clearAll      = 1'b1;
                    flushPendNext = 1'b0;
                end
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State registers; reset abandons any refill in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg     <= IDLE;
            cntReg       <= '0;
            missTagReg   <= '0;
            missIdxReg   <= '0;
            memReqReg    <= 1'b0;
            memAddrReg   <= '0;
            flushPendReg <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            cntReg       <= cntNext;
            missTagReg   <= missTagNext;
            missIdxReg   <= missIdxNext;
            memReqReg    <= memReqNext;
            memAddrReg   <= memAddrNext;
            flushPendReg <= flushPendNext;
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed scoreboard bench for icache_ctrl: a memory responder serves refill
// beats, the stimulus queues expected fetch data and refill addresses, and a
// monitor compares them whenever the cache returns data or takes a beat.
module tb_icache_ctrl;

    logic clk;
    logic reset;

    icache_ctrl_if bus();

    icache_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors;
    int          miscompares;
    logic [31:0] expRdata[$];
    logic [31:0] expMemAddr[$];
    int          gap;
    logic [31:0] refillBase;
    int          strayWanted;
    int          strayDone;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    // Memory model: acks after `gap` idle cycles per beat, data = base + word.
    initial begin : responder
        int waitCnt;
        waitCnt = 0;
        strayDone = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                if (waitCnt >= gap) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = refillBase + 32'(bus.mem_addr[3:2]);
                    waitCnt = 0;
                end else begin
                    waitCnt++;
                end
            end else begin
                waitCnt = 0;
                if (strayDone != strayWanted) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = 32'hDEAD_BEEF;
                    strayDone++;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on delivered fetches and accepted beats,
    // and checks that an unacknowledged request holds steady.
    initial begin : monitor
        logic        prevReq, prevAck, prevReset;
        logic [31:0] prevAddr;
        logic [31:0] expv;
        prevReq = 1'b0;
        prevAck = 1'b0;
        prevReset = 1'b1;
        prevAddr = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.req_valid && bus.hit && !reset) begin
                if (expRdata.size() == 0) begin
                    check("unexpected_hit", 32'(bus.hit), 32'h0);
                end else begin
                    expv = expRdata.pop_front();
                    check("rdata", bus.rdata, expv);
                end
            end
            if (bus.mem_req && bus.mem_ack) begin
                if (expMemAddr.size() == 0) begin
                    check("unexpected_beat", bus.mem_addr, 32'hFFFF_FFFF);
                end else begin
                    expv = expMemAddr.pop_front();
                    check("mem_addr", bus.mem_addr, expv);
                end
            end
            if (prevReq && !prevAck && !prevReset) begin
                check("mem_req_hold", 32'(bus.mem_req), 32'h1);
                check("mem_addr_hold", bus.mem_addr, prevAddr);
            end
            prevReq = bus.mem_req;
            prevAck = bus.mem_ack;
            prevReset = reset;
            prevAddr = bus.mem_addr;
        end
    end

    // Issue one fetch and hold it until hit; checks the stall length.
    task automatic doFetch(input logic [31:0] addr, input logic [31:0] expData,
                           input int expStall, input int beats);
        logic [31:0] lineBase;
        int stall;
        bit done;
        lineBase = {addr[31:4], 4'h0};
        for (int i = 0; i < beats; i++) begin
            expMemAddr.push_back(lineBase + 32'(4 * (i % 4)));
        end
        expRdata.push_back(expData);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr = addr;
        stall = 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (bus.hit) done = 1'b1;
            else stall++;
        end
        if (!done) begin
            check("fetch_timeout", 32'(done), 32'h1);
        end else begin
            check("stall_cycles", 32'(stall), 32'(expStall));
            check("hit_mem_req_low", 32'(bus.mem_req), 32'h0);
        end
        $display("fetch addr=%h stall=%0d rdata=%h", addr, stall, bus.rdata);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin : stimulus
        vectors = 0;
        miscompares = 0;
        gap = 0;
        refillBase = 32'h0;
        strayWanted = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr = 32'h0;
        bus.flush = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hit", 32'(bus.hit), 32'h0);
        check("reset_mem_req", 32'(bus.mem_req), 32'h0);
        check("reset_mem_addr", bus.mem_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_hit", 32'(bus.hit), 32'h1);

        // Cold miss, then a hit in the same line
        refillBase = 32'hA0;
        doFetch(32'h0000_0040, 32'hA0, 6, 4);
        doFetch(32'h0000_0048, 32'hA2, 0, 0);

        // Conflict on index 4 evicts 0x40
        refillBase = 32'hB0;
        doFetch(32'h0000_1040, 32'hB0, 6, 4);
        refillBase = 32'hA0;
        doFetch(32'h0000_0040, 32'hA0, 6, 4);
        doFetch(32'h0000_004C, 32'hA3, 0, 0);

        // Two idle cycles before every ack, then a stray ack while idle
        gap = 2;
        refillBase = 32'hE0;
        doFetch(32'h0000_0108, 32'hE2, 14, 4);
        gap = 0;
        strayWanted++;
        repeat (4) @(posedge clk);
        doFetch(32'h0000_0100, 32'hE0, 0, 0);
        doFetch(32'h0000_010C, 32'hE3, 0, 0);

        // Flush in IDLE together with a miss: clears, starts no refill
        @(posedge clk);
        #1;
        bus.flush = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0000_0300;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("flush_idle_no_refill", 32'(bus.mem_req), 32'h0);
        refillBase = 32'hE0;
        doFetch(32'h0000_0100, 32'hE0, 6, 4);

        // Flush during a refill: line finishes, is cleared in DONE, re-misses
        gap = 2;
        refillBase = 32'hC0;
        fork
            doFetch(32'h0000_0084, 32'hC1, 28, 8);
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.flush = 1'b1;
                @(posedge clk);
                #1;
                bus.flush = 1'b0;
            end
        join
        doFetch(32'h0000_0084, 32'hC1, 0, 0);

        // Reset after the first beat of a refill
        gap = 0;
        refillBase = 32'hD0;
        expMemAddr.push_back(32'h0000_00C0);
        expMemAddr.push_back(32'h0000_00C4);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_addr = 32'h0000_00C0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("reset_mid_mem_req", 32'(bus.mem_req), 32'h0);
        check("reset_mid_mem_addr", bus.mem_addr, 32'h0);
        check("reset_mid_idle_hit", 32'(bus.hit), 32'h1);
        $display("reset during refill of line %h", 32'h0000_00C0);
        doFetch(32'h0000_00C0, 32'hD0, 6, 4);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rdata_queue_drained", 32'(expRdata.size()), 32'h0);
        check("beat_queue_drained", 32'(expMemAddr.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
